// File: rtl/rob.sv
// Reorder buffer: a circular queue of in-flight instructions. Completions may arrive out of
// order; commits leave in order. Optional entry-query ports are enabled by ROB_QUERY_EN.
`ifndef ROB_DEFS
`define ROB_DEFS
`define InstrIdWidth 6
`define RegIdxWidth 5
`define ROBIdxWidth 4
`define ROBSize 16
`define LUI   6'd1
`define AUIPC 6'd2
`define JAL   6'd3
`define JALR  6'd4
`define BEQ   6'd5
`define BNE   6'd6
`define BLT   6'd7
`define BGE   6'd8
`define BLTU  6'd9
`define BGEU  6'd10
`define LB    6'd11
`define LH    6'd12
`define LW    6'd13
`define LBU   6'd14
`define LHU   6'd15
`define SB    6'd16
`define SH    6'd17
`define SW    6'd18
`define ADDI  6'd19
`define AND   6'd37
`endif

module rob (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     issue_to_rob_en_in,
    input  logic [`InstrIdWidth-1:0] instr_id_in,
    input  logic [`RegIdxWidth-1:0]  rd_in,
    input  logic [31:0]              pc_in,
    output logic                     rob_empty_out,
    output logic [`ROBIdxWidth-1:0]  rob_head_out,
    output logic [`ROBIdxWidth-1:0]  rob_tail_out,
    input  logic                     alu_en_in,
    input  logic [`ROBIdxWidth-1:0]  alu_idx_in,
    input  logic [31:0]              alu_val_in,
    input  logic                     alu_jump_in,
    input  logic [31:0]              alu_pc_in,
    input  logic                     lsb_en_in,
    input  logic [`ROBIdxWidth-1:0]  lsb_idx_in,
    input  logic [31:0]              lsb_val_in,
    output logic                     commit_reg_en_out,
    output logic [`RegIdxWidth-1:0]  commit_rd_out,
    output logic [31:0]              commit_val_out,
    output logic [`ROBIdxWidth-1:0]  commit_idx_out,
    output logic                     commit_store_en_out,
    output logic [`ROBIdxWidth-1:0]  commit_store_idx_out,
`ifdef ROB_QUERY_EN
    input  logic [`ROBIdxWidth-1:0]  query1_idx_in,
    input  logic [`ROBIdxWidth-1:0]  query2_idx_in,
    output logic                     query1_ready_out,
    output logic [31:0]              query1_val_out,
    output logic                     query2_ready_out,
    output logic [31:0]              query2_val_out,
`endif
    output logic                     clear_out,
    output logic [31:0]              clear_pc_out
);
    localparam int N  = `ROBSize;
    localparam int IW = `ROBIdxWidth;

    logic [IW-1:0]            head_q, head_d, tail_q, tail_d;
    logic                     empty_q, empty_d;
    logic [N-1:0]             busy_q, busy_d, ready_q, ready_d, jump_q, jump_d;
    logic [`InstrIdWidth-1:0] id_q [N];
    logic [`InstrIdWidth-1:0] id_d [N];
    logic [`RegIdxWidth-1:0]  rd_q [N];
    logic [`RegIdxWidth-1:0]  rd_d [N];
    logic [31:0]              val_q [N];
    logic [31:0]              val_d [N];
    logic [31:0]              target_q [N];
    logic [31:0]              target_d [N];

    logic [`InstrIdWidth-1:0] head_id;
    logic                     head_is_store, head_is_branch;
    logic                     commit_fire, reg_commit, full, issue_ok;
    logic [IW-1:0]            head_inc, tail_inc;

    assign head_inc       = head_q + IW'(1);
    assign tail_inc       = tail_q + IW'(1);
    assign full           = !empty_q && (head_q == tail_q);
    assign issue_ok       = rdy_in && issue_to_rob_en_in && !full;
    assign head_id        = id_q[head_q];
    assign head_is_store  = (head_id >= `SB) && (head_id <= `SW);
    assign head_is_branch = (head_id >= `BEQ) && (head_id <= `BGEU);

    // Commit reads only registered ready bits, so a completion is committable a cycle later.
    assign commit_fire = rdy_in && !empty_q && busy_q[head_q] && ready_q[head_q];
    assign reg_commit  = commit_fire && !head_is_store && !head_is_branch && (rd_q[head_q] != '0);

    assign rob_empty_out        = empty_q;
    assign rob_head_out         = head_q;
    assign rob_tail_out         = tail_q;
    assign commit_reg_en_out    = reg_commit;
    assign commit_rd_out        = reg_commit ? rd_q[head_q] : '0;
    assign commit_val_out       = reg_commit ? val_q[head_q] : '0;
    assign commit_idx_out       = reg_commit ? head_q : '0;
    assign commit_store_en_out  = commit_fire && head_is_store;
    assign commit_store_idx_out = (commit_fire && head_is_store) ? head_q : '0;
    assign clear_out            = commit_fire && jump_q[head_q];
    assign clear_pc_out         = (commit_fire && jump_q[head_q]) ? target_q[head_q] : '0;

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        empty_d  = empty_q;
        busy_d   = busy_q;
        ready_d  = ready_q;
        jump_d   = jump_q;
        id_d     = id_q;
        rd_d     = rd_q;
        val_d    = val_q;
        target_d = target_q;
        if (clear_out) begin
            // A mispredict squashes everything younger, including this cycle's issue/completions.
            busy_d  = '0;
            ready_d = '0;
            jump_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            empty_d = 1'b1;
        end else if (rdy_in) begin
            if (alu_en_in && busy_q[alu_idx_in]) begin
                ready_d[alu_idx_in]  = 1'b1;
                val_d[alu_idx_in]    = alu_val_in;
                jump_d[alu_idx_in]   = alu_jump_in;
                target_d[alu_idx_in] = alu_pc_in;
            end
            if (lsb_en_in && busy_q[lsb_idx_in]) begin
                ready_d[lsb_idx_in] = 1'b1;
                val_d[lsb_idx_in]   = lsb_val_in;
                jump_d[lsb_idx_in]  = 1'b0;
            end
            if (commit_fire) begin
                busy_d[head_q]  = 1'b0;
                ready_d[head_q] = 1'b0;
                head_d          = head_inc;
                if (!issue_ok && (head_inc == tail_q)) empty_d = 1'b1;
            end
            if (issue_ok) begin
                busy_d[tail_q]   = 1'b1;
                ready_d[tail_q]  = 1'b0;
                jump_d[tail_q]   = 1'b0;
                id_d[tail_q]     = instr_id_in;
                rd_d[tail_q]     = rd_in;
                target_d[tail_q] = pc_in;
                tail_d           = tail_inc;
                empty_d          = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            empty_q <= 1'b1;
            busy_q  <= '0;
            ready_q <= '0;
            jump_q  <= '0;
            for (int i = 0; i < N; i++) begin
                id_q[i]     <= '0;
                rd_q[i]     <= '0;
                val_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            empty_q  <= empty_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            jump_q   <= jump_d;
            id_q     <= id_d;
            rd_q     <= rd_d;
            val_q    <= val_d;
            target_q <= target_d;
        end
    end

`ifdef ROB_QUERY_EN
    // Bypass lets a consumer see a result in the same cycle it is broadcast.
    always_comb begin
        query1_ready_out = ready_q[query1_idx_in];
        query1_val_out   = val_q[query1_idx_in];
        if (lsb_en_in && busy_q[query1_idx_in] && (lsb_idx_in == query1_idx_in)) begin
            query1_ready_out = 1'b1;
            query1_val_out   = lsb_val_in;
        end
        if (alu_en_in && busy_q[query1_idx_in] && (alu_idx_in == query1_idx_in)) begin
            query1_ready_out = 1'b1;
            query1_val_out   = alu_val_in;
        end
    end

    always_comb begin
        query2_ready_out = ready_q[query2_idx_in];
        query2_val_out   = val_q[query2_idx_in];
        if (lsb_en_in && busy_q[query2_idx_in] && (lsb_idx_in == query2_idx_in)) begin
            query2_ready_out = 1'b1;
            query2_val_out   = lsb_val_in;
        end
        if (alu_en_in && busy_q[query2_idx_in] && (alu_idx_in == query2_idx_in)) begin
            query2_ready_out = 1'b1;
            query2_val_out   = alu_val_in;
        end
    end
`endif

endmodule

// File: tb/tb_rob.sv
// Bench for rob: directed issue/complete sequences; commit events are predicted into a
// queue and checked by an independent monitor on the falling edge.
module tb_rob;
    localparam logic [5:0] ID_BEQ  = 6'd5;
    localparam logic [5:0] ID_LW   = 6'd13;
    localparam logic [5:0] ID_SW   = 6'd18;
    localparam logic [5:0] ID_ADDI = 6'd19;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, issue_en;
    logic [5:0]  instr_id;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        rob_empty_out;
    logic [3:0]  rob_head_out, rob_tail_out;
    logic        alu_en, alu_jump, lsb_en;
    logic [3:0]  alu_idx, lsb_idx;
    logic [31:0] alu_val, alu_pc, lsb_val;
    logic        commit_reg_en_out, commit_store_en_out, clear_out;
    logic [4:0]  commit_rd_out;
    logic [31:0] commit_val_out, clear_pc_out;
    logic [3:0]  commit_idx_out, commit_store_idx_out;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [43:0] exp_q[$];
    logic [43:0] mon_act, mon_exp;

    rob dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_to_rob_en_in(issue_en), .instr_id_in(instr_id), .rd_in(rd), .pc_in(pc),
        .rob_empty_out(rob_empty_out), .rob_head_out(rob_head_out), .rob_tail_out(rob_tail_out),
        .alu_en_in(alu_en), .alu_idx_in(alu_idx), .alu_val_in(alu_val),
        .alu_jump_in(alu_jump), .alu_pc_in(alu_pc),
        .lsb_en_in(lsb_en), .lsb_idx_in(lsb_idx), .lsb_val_in(lsb_val),
        .commit_reg_en_out(commit_reg_en_out), .commit_rd_out(commit_rd_out),
        .commit_val_out(commit_val_out), .commit_idx_out(commit_idx_out),
        .commit_store_en_out(commit_store_en_out), .commit_store_idx_out(commit_store_idx_out),
        .clear_out(clear_out), .clear_pc_out(clear_pc_out)
    );

    // clock / reset
    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [43:0] act, input logic [43:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // event encoding: {reg_en, store_en, clear, rd, value, idx}
    function automatic logic [43:0] ev_reg(input logic [4:0] r, input logic [31:0] v, input logic [3:0] i);
        return {3'b100, r, v, i};
    endfunction
    function automatic logic [43:0] ev_store(input logic [3:0] i);
        return {3'b010, 5'd0, 32'd0, i};
    endfunction
    function automatic logic [43:0] ev_clear(input logic [31:0] p);
        return {3'b001, 5'd0, p, 4'd0};
    endfunction

    // driver tasks
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_inputs();
        issue_en = 0; instr_id = '0; rd = '0; pc = '0;
        alu_en = 0; alu_idx = '0; alu_val = '0; alu_jump = 0; alu_pc = '0;
        lsb_en = 0; lsb_idx = '0; lsb_val = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        #1 rst_in = 1;
        @(posedge clk);
        #2 rst_in = 0;
    endtask

    task automatic issue(input logic [5:0] id, input logic [4:0] r, input logic [31:0] p);
        issue_en = 1; instr_id = id; rd = r; pc = p;
        step();
        issue_en = 0;
    endtask

    task automatic alu(input logic [3:0] i, input logic [31:0] v, input logic j, input logic [31:0] p);
        alu_en = 1; alu_idx = i; alu_val = v; alu_jump = j; alu_pc = p;
        step();
        alu_en = 0; alu_jump = 0;
    endtask

    task automatic lsb(input logic [3:0] i, input logic [31:0] v);
        lsb_en = 1; lsb_idx = i; lsb_val = v;
        step();
        lsb_en = 0;
    endtask

    task automatic check_ptrs(input string name, input logic [3:0] h, input logic [3:0] t, input logic e);
        check(name, {rob_head_out, rob_tail_out, rob_empty_out}, {h, t, e});
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst_in && (commit_reg_en_out || commit_store_en_out || clear_out)) begin
            mon_act = {commit_reg_en_out, commit_store_en_out, clear_out, commit_rd_out,
                       clear_out ? clear_pc_out : commit_val_out,
                       commit_reg_en_out ? commit_idx_out : commit_store_idx_out};
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_commit: got %h expected none at %0t", mon_act, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("commit_event", mon_act, mon_exp);
            end
        end
    end

    initial begin
        rst_in = 1;
        rdy_in = 1;
        clear_inputs();
        #1;
        check_ptrs("reset_state", 4'd0, 4'd0, 1'b1);
        check("reset_pulses", {commit_reg_en_out, commit_store_en_out, clear_out}, 3'b000);
        @(posedge clk);
        #2 rst_in = 0;

        // fill all 16 entries, tail wraps; further issue ignored
        issue_en = 1; instr_id = ID_ADDI; rd = 5'd1; pc = 32'h0;
        idle(8);
        check_ptrs("fill_half", 4'd0, 4'd8, 1'b0);
        idle(8);
        check_ptrs("fill_full", 4'd0, 4'd0, 1'b0);
        step();
        check_ptrs("issue_when_full", 4'd0, 4'd0, 1'b0);
        issue_en = 0;

        // single ALU op commits one cycle after completion
        do_reset();
        issue(ID_ADDI, 5'd5, 32'h10);
        exp_q.push_back(ev_reg(5'd5, 32'h2A, 4'd0));
        alu(4'd0, 32'h2A, 1'b0, 32'h0);
        check("commit_next_cycle", commit_reg_en_out, 1'b1);
        idle(1);
        check_ptrs("after_single", 4'd1, 4'd1, 1'b1);

        // out-of-order completion, in-order commit on consecutive cycles
        do_reset();
        issue(ID_ADDI, 5'd3, 32'h20);
        issue(ID_ADDI, 5'd4, 32'h24);
        exp_q.push_back(ev_reg(5'd3, 32'h22, 4'd0));
        exp_q.push_back(ev_reg(5'd4, 32'h11, 4'd1));
        alu(4'd1, 32'h11, 1'b0, 32'h0);
        check_ptrs("ooo_no_early_commit", 4'd0, 4'd2, 1'b0);
        alu(4'd0, 32'h22, 1'b0, 32'h0);
        idle(2);
        check_ptrs("ooo_drained", 4'd2, 4'd2, 1'b1);

        // ALU and LSB completing the same cycle
        issue(ID_ADDI, 5'd7, 32'h28);
        issue(ID_LW, 5'd8, 32'h2C);
        exp_q.push_back(ev_reg(5'd7, 32'h77, 4'd2));
        exp_q.push_back(ev_reg(5'd8, 32'h88, 4'd3));
        alu_en = 1; alu_idx = 4'd2; alu_val = 32'h77;
        lsb_en = 1; lsb_idx = 4'd3; lsb_val = 32'h88;
        step();
        alu_en = 0; lsb_en = 0;
        idle(2);
        check_ptrs("dual_drained", 4'd4, 4'd4, 1'b1);

        // mispredicted branch flushes younger entries and same-cycle issue
        do_reset();
        issue(ID_BEQ, 5'd0, 32'h40);
        issue(ID_ADDI, 5'd9, 32'h44);
        alu(4'd1, 32'h5, 1'b0, 32'h0);
        exp_q.push_back(ev_clear(32'h100));
        alu(4'd0, 32'h0, 1'b1, 32'h100);
        issue_en = 1; instr_id = ID_ADDI; rd = 5'd12;
        lsb_en = 1; lsb_idx = 4'd1; lsb_val = 32'h9;
        step();
        issue_en = 0; lsb_en = 0;
        check_ptrs("after_flush", 4'd0, 4'd0, 1'b1);
        idle(3);
        check_ptrs("flush_stays_empty", 4'd0, 4'd0, 1'b1);

        // store commit: store pulse, no register write
        do_reset();
        issue(ID_SW, 5'd3, 32'h50);
        exp_q.push_back(ev_store(4'd0));
        lsb(4'd0, 32'h1234);
        idle(2);
        check_ptrs("store_drained", 4'd1, 4'd1, 1'b1);

        // rdy_in low stalls commit and issue
        do_reset();
        issue(ID_ADDI, 5'd10, 32'h60);
        exp_q.push_back(ev_reg(5'd10, 32'h55, 4'd0));
        alu_en = 1; alu_idx = 4'd0; alu_val = 32'h55;
        step();
        alu_en = 0; rdy_in = 0;
        issue_en = 1; instr_id = ID_ADDI; rd = 5'd11;
        #1 check("stall_no_pulse", {commit_reg_en_out, commit_store_en_out, clear_out}, 3'b000);
        step();
        check_ptrs("stall_hold", 4'd0, 4'd1, 1'b0);
        issue_en = 0; rdy_in = 1;
        idle(2);
        check_ptrs("stall_resume", 4'd1, 4'd1, 1'b1);

        // asynchronous reset between edges with live entries
        do_reset();
        issue(ID_ADDI, 5'd1, 32'h70);
        issue(ID_ADDI, 5'd2, 32'h74);
        issue(ID_ADDI, 5'd3, 32'h78);
        alu(4'd0, 32'h1, 1'b0, 32'h0);
        #1 rst_in = 1;
        #1;
        check("async_rst_pulse", {commit_reg_en_out, commit_store_en_out, clear_out}, 3'b000);
        check_ptrs("async_rst_ptrs", 4'd0, 4'd0, 1'b1);
        @(posedge clk);
        #2 rst_in = 0;
        idle(2);
        check_ptrs("post_rst_idle", 4'd0, 4'd0, 1'b1);

        idle(2);
        check("queue_drained", 44'(exp_q.size()), 44'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 clk_in  input  1  single clock; all state updates on rising edge.
REQ-002 rst_in  input  1  asynchronous, active-high reset.
REQ-003 rdy_in  input  1  global ready; low = hold all state, no outputs pulsed.
REQ-004 issue_to_rob_en_in  input  1  allocate entry at tail this cycle.
REQ-005 instr_id_in / rd_in / pc_in  input  `InstrIdWidth / `RegIdxWidth / 32  fields of issued instruction.
REQ-006 rob_empty_out, rob_head_out, rob_tail_out  output  1 / `ROBIdxWidth / `ROBIdxWidth  queue state for issue; full = !empty && head==tail.
REQ-007 alu_en_in, alu_idx_in, alu_val_in, alu_jump_in, alu_pc_in  input  1 / `ROBIdxWidth / 32 / 1 / 32  ALU completion: result, taken-redirect flag, redirect target.
REQ-008 lsb_en_in, lsb_idx_in, lsb_val_in  input  1 / `ROBIdxWidth / 32  LSB completion (load data, or store address/data ready).
REQ-009 commit_reg_en_out, commit_rd_out, commit_val_out, commit_idx_out  output  1 / `RegIdxWidth / 32 / `ROBIdxWidth  register writeback at commit.
REQ-010 commit_store_en_out, commit_store_idx_out  output  1 / `ROBIdxWidth  permit LSB to perform store at head.
REQ-011 clear_out, clear_pc_out  output  1 / 32  pipeline flush and fetch restart PC.

Function
REQ-012 Circular buffer of `ROBSize entries; each: busy, ready, instr_id, rd, value, jump, target.
REQ-013 Issue: when issue_to_rob_en_in && !full, entry[tail] loaded busy=1, ready=0, jump=0; tail = tail+1 mod `ROBSize; empty cleared.
REQ-014 Issue while full SHALL be ignored (no state change).
REQ-015 Completion (ALU or LSB, both may fire same cycle on distinct indices): entry[idx] ready=1, value/jump/target written; completion to non-busy entry ignored.
REQ-016 Commit: at most one per cycle, when !empty && entry[head].ready; head = head+1; busy cleared; empty set if new head==tail and no same-cycle issue.
REQ-017 Ready set by a completion is visible to commit no earlier than the following cycle.
REQ-018 Commit of load/ALU/JAL/JALR/LUI/AUIPC with rd!=0: one-cycle pulse of commit_reg_en_out with rd, value, head index.
REQ-019 Commit of store (`SB..`SW): one-cycle pulse of commit_store_en_out with head index; no register write.
REQ-020 Commit of entry with jump=1 (mispredict; fetch predicts not-taken): also pulse clear_out, clear_pc_out=target for one cycle; next cycle all entries invalid, head=tail=0, empty=1.
REQ-021 Flush takes priority over issue and completions in the same cycle; those are discarded.
REQ-022 Simultaneous issue and commit with one occupied entry: empty stays 0, both pointers advance.
REQ-023 Pointer wrap: `ROBSize-1 + 1 = 0.
REQ-024 All pulse outputs low in any cycle without the corresponding event and whenever rdy_in=0.

Reset
REQ-025 rst_in high SHALL immediately force head=tail=0, empty=1, all busy/ready=0, all outputs 0, regardless of clock.
REQ-026 Reset mid-operation discards all in-flight entries; no commit pulse emitted on the release cycle.

Configuration
REQ-027 Macro ROB_QUERY_EN: when defined, adds inputs query1_idx_in, query2_idx_in (`ROBIdxWidth) and outputs query1_ready_out, query1_val_out, query2_ready_out, query2_val_out, combinationally returning ready/value of the indexed entry, including same-cycle bypass of a matching ALU/LSB completion.
REQ-028 Without ROB_QUERY_EN those ports are absent and no bypass logic exists; all other behaviour identical.

Verification
REQ-029 Reset then issue 16 ADDI: tail wraps to 0, head=0, empty=0 (full); 17th issue ignored.
REQ-030 Issue ADDI rd=5 idx0; ALU completes idx0 val=0x2A at cycle t -> commit_reg_en_out=1, rd=5, val=0x2A at cycle t+1, empty=1 after.
REQ-031 Out-of-order completion idx1 before idx0 -> commits strictly idx0 then idx1 on consecutive cycles.
REQ-032 Issue BEQ idx0, ADDI idx1; ALU completes idx0 jump=1 pc=0x100 -> clear_out pulse, clear_pc_out=0x100, next cycle head=tail=0, empty=1, idx1 never commits.
REQ-033 Issue SW idx0; LSB completes idx0 -> commit_store_en_out=1 idx=0, commit_reg_en_out=0.
REQ-034 rst_in asserted between clock edges with 3 entries live -> outputs zero immediately, empty=1.
